// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - timer flag inputs and interrupt-entry control outputs
interface interrupt_sequencer_if #(
  parameter int PC_W = 14
);
  logic [7:0]      tifr;
  logic [7:0]      timsk;
  logic            sreg_i;
  logic            instr_boundary;
  logic            busy;
  logic [2:0]      int_stage;
  logic            mem_we;
  logic            sp_dec;
  logic            pc_overwrite;
  logic [PC_W-1:0] vector;
  logic [7:0]      tifr_clr;

  modport master (
    output tifr, timsk, sreg_i, instr_boundary,
    input  busy, int_stage, mem_we, sp_dec, pc_overwrite, vector, tifr_clr
  );

  modport slave (
    input  tifr, timsk, sreg_i, instr_boundary,
    output busy, int_stage, mem_we, sp_dec, pc_overwrite, vector, tifr_clr
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - timer interrupt arbitration and four-cycle entry sequence
module interrupt_sequencer #(
  parameter int              PC_W         = 14,
  parameter logic [PC_W-1:0] VEC_T1_COMPA = 14'h00E,
  parameter logic [PC_W-1:0] VEC_T0_COMP  = 14'h014,
  parameter logic [PC_W-1:0] VEC_T0_OVF   = 14'h016
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH_L = 3'd1,
    S_PUSH_H = 3'd2,
    S_CLR_I  = 3'd3,
    S_JUMP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      winner_q, winner_d;
  logic [PC_W-1:0] vector_q, vector_d;
  logic [7:0]      pending;

  // Only the three timer sources we vector are considered.
  assign pending = bus.tifr & bus.timsk & 8'h13;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      winner_q <= 8'h00;
      vector_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      vector_q <= vector_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    vector_d = vector_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_boundary && bus.sreg_i && (|pending)) begin
          state_d = S_PUSH_L;
          if (pending[4]) begin
            winner_d = 8'h10;
            vector_d = VEC_T1_COMPA;
          end else if (pending[1]) begin
            winner_d = 8'h02;
            vector_d = VEC_T0_COMP;
          end else begin
            winner_d = 8'h01;
            vector_d = VEC_T0_OVF;
          end
        end
      end
      S_PUSH_L: state_d = S_PUSH_H;
      S_PUSH_H: state_d = S_CLR_I;
      S_CLR_I:  state_d = S_JUMP;
      S_JUMP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state register only, so reset silences them immediately.
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.int_stage    = state_q;
  assign bus.mem_we       = (state_q == S_PUSH_L) || (state_q == S_PUSH_H) || (state_q == S_CLR_I);
  assign bus.sp_dec       = (state_q == S_PUSH_L) || (state_q == S_PUSH_H);
  assign bus.pc_overwrite = (state_q == S_JUMP);
  assign bus.tifr_clr     = (state_q == S_JUMP) ? winner_q : 8'h00;
  assign bus.vector       = vector_q;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - randomized and directed checks against a behavioural model
module tb_interrupt_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  interrupt_sequencer_if #(.PC_W(14)) bus ();

  interrupt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  g_tifr  = 8'h00;
  logic [7:0]  g_timsk = 8'h00;
  logic        g_sreg  = 1'b0;

  int          exp_stage = 0;
  int          stage_q[$];
  logic [13:0] m_vec = 14'h0;
  logic [7:0]  m_clr = 8'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void pick(input logic [7:0] p, output logic [13:0] v, output logic [7:0] c);
    int          bits[3] = '{4, 1, 0};
    logic [13:0] vecs[3] = '{14'h00E, 14'h014, 14'h016};
    v = 14'h0;
    c = 8'h0;
    for (int i = 2; i >= 0; i--)
      if (p[bits[i]]) begin
        v = vecs[i];
        c = 8'h1 << bits[i];
      end
  endfunction

  function automatic void model_reset();
    exp_stage = 0;
    stage_q.delete();
    m_vec = 14'h0;
    m_clr = 8'h0;
  endfunction

  function automatic void model_edge(input logic ib);
    logic [7:0] p;
    p = g_tifr & g_timsk & 8'h13;
    if (exp_stage == 0) begin
      if (ib && g_sreg && p != 0) begin
        pick(p, m_vec, m_clr);
        stage_q = '{2, 3, 4};
        exp_stage = 1;
      end
    end else begin
      exp_stage = (stage_q.size() > 0) ? stage_q.pop_front() : 0;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".busy"},   bus.busy, exp_stage != 0);
    check({tag, ".stage"},  bus.int_stage, exp_stage);
    check({tag, ".mem_we"}, bus.mem_we, exp_stage >= 1 && exp_stage <= 3);
    check({tag, ".sp_dec"}, bus.sp_dec, exp_stage == 1 || exp_stage == 2);
    check({tag, ".pc_ow"},  bus.pc_overwrite, exp_stage == 4);
    check({tag, ".vector"}, bus.vector, m_vec);
    check({tag, ".clr"},    bus.tifr_clr, (exp_stage == 4) ? m_clr : 8'h00);
  endtask

  // One clock: drive, edge, update model, check, then apply write-1-to-clear.
  task automatic cyc(input string tag, input logic ib);
    bus.tifr           = g_tifr;
    bus.timsk          = g_timsk;
    bus.sreg_i         = g_sreg;
    bus.instr_boundary = ib;
    @(posedge clk);
    model_edge(ib);
    #1;
    check_all(tag);
    if (exp_stage == 4) g_tifr = g_tifr & ~m_clr;
  endtask

  initial begin
    bus.tifr = 8'h00;
    bus.timsk = 8'h00;
    bus.sreg_i = 1'b0;
    bus.instr_boundary = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // single source
    g_tifr = 8'h02; g_timsk = 8'h02; g_sreg = 1'b1;
    cyc("single", 1'b1);
    check("single.st1", bus.int_stage, 1);
    for (int i = 0; i < 3; i++) cyc("single", 1'b0);
    check("single.vec", bus.vector, 14'h014);
    check("single.clr", bus.tifr_clr, 8'h02);
    cyc("single.after", 1'b0);
    check("single.clr_gone", bus.tifr_clr, 8'h00);

    // priority: three entries, each after SEI and a boundary
    g_tifr = 8'h13; g_timsk = 8'h13;
    for (int k = 0; k < 3; k++) begin
      g_sreg = 1'b1;
      cyc("prio", 1'b1);
      for (int i = 0; i < 3; i++) cyc("prio", 1'b0);
      g_sreg = 1'b0;
      cyc("prio.idle", 1'b0);
    end
    check("prio.flags_served", g_tifr, 8'h00);

    // masked, then disabled
    g_tifr = 8'h01; g_timsk = 8'h00; g_sreg = 1'b1;
    for (int i = 0; i < 10; i++) cyc("masked", 1'b1);
    g_timsk = 8'h01; g_sreg = 1'b0;
    for (int i = 0; i < 10; i++) cyc("disabled", 1'b1);
    check("disabled.flag_kept", bus.tifr, 8'h01);

    // flag drop during PUSH_L
    g_tifr = 8'h10; g_timsk = 8'h10; g_sreg = 1'b1;
    cyc("drop", 1'b1);
    g_tifr = 8'h00;
    for (int i = 0; i < 3; i++) cyc("drop", 1'b0);
    check("drop.vec", bus.vector, 14'h00E);
    check("drop.clr", bus.tifr_clr, 8'h10);
    cyc("drop.idle", 1'b0);

    // boundary gating
    g_tifr = 8'h01; g_timsk = 8'h01; g_sreg = 1'b1;
    for (int i = 0; i < 5; i++) cyc("gate", 1'b0);
    check("gate.idle", bus.busy, 1'b0);
    cyc("gate.entry", 1'b1);
    check("gate.st1", bus.int_stage, 1);
    for (int i = 0; i < 4; i++) cyc("gate", 1'b0);

    // reset during PUSH_H
    g_tifr = 8'h02; g_timsk = 8'h02; g_sreg = 1'b1;
    cyc("rst.seq", 1'b1);
    cyc("rst.seq", 1'b0);
    check("rst.in_push_h", bus.int_stage, 2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("rst.async");
    @(posedge clk);
    #1;
    check_all("rst.held");
    rst = 1'b0;
    g_sreg = 1'b0;
    for (int i = 0; i < 4; i++) cyc("rst.after", 1'b1);

    // randomized traffic
    g_tifr = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) g_timsk = 8'($urandom);
      if ($urandom_range(0, 5) == 0) g_tifr = g_tifr | 8'($urandom);
      if ($urandom_range(0, 9) == 0) g_tifr = g_tifr & 8'($urandom);
      g_sreg = ($urandom_range(0, 3) != 0);
      cyc("rand", $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
